// File: rtl/life_word_fsm.sv
// life_word_fsm: btn synchronizer/debouncer, lives counter and Play/Arm/Live/Dead FSM producing wordSelect.
// Latency: btn rise (stable) to press = 2 + DEBOUNCE_CYCLES + 1 cycles; wordSelect is decoded from registered state.
// Backpressure: none; every press/hit cycle is consumed or dropped in the same cycle. Option macro: DEAD_BLINK_EN.
module life_word_fsm #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLANK_CYCLES    = 50_000_000,
  parameter int LIVES           = 3,
  parameter int BLINK_CYCLES    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       hit,
  output logic [1:0] wordSelect,
  output logic [2:0] lives,
  output logic       press
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  // Reject configurations the counters cannot represent.
  if (LIVES < 1 || LIVES > 7 || DEBOUNCE_CYCLES < 1 || BLANK_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
    $error("life_word_fsm: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_LIVE = 2'd1,
    S_DEAD = 2'd2,
    S_ARM  = 2'd3
  } state_t;

  logic          sync1, sync2;
  logic          db_lvl, db_prev;
  logic [DW-1:0] db_cnt;

  state_t        state, state_n;
  logic [AW-1:0] arm_cnt, arm_n;
  logic [2:0]    lives_n;

  // Two-flop synchronizer, debounce counter and one-cycle press pulse on a debounced rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db_lvl;
      press   <= db_lvl & ~db_prev;
      if (sync2 != db_lvl) begin
        if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Game state, arm timer and lives registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_PLAY;
      arm_cnt <= '0;
      lives   <= 3'(LIVES);
    end else begin
      state   <= state_n;
      arm_cnt <= arm_n;
      lives   <= lives_n;
    end
  end

  // Next-state logic; press wins over a same-cycle hit in Live.
  always_comb begin
    state_n = state;
    arm_n   = arm_cnt;
    lives_n = lives;
    case (state)
      S_PLAY: begin
        if (press) begin
          state_n = S_ARM;
          arm_n   = '0;
          lives_n = 3'(LIVES);
        end
      end
      S_ARM: begin
        if (arm_cnt == AW'(BLANK_CYCLES - 1)) begin
          state_n = S_LIVE;
          arm_n   = '0;
        end else begin
          arm_n = arm_cnt + AW'(1);
        end
      end
      S_LIVE: begin
        if (press) begin
          state_n = S_PLAY;
          lives_n = 3'(LIVES);
        end else if (hit) begin
          if (lives > 3'd1) begin
            lives_n = lives - 3'd1;
          end else begin
            lives_n = 3'd0;
            state_n = S_DEAD;
          end
        end
      end
      S_DEAD: begin
        lives_n = 3'd0;
        if (press) begin
          state_n = S_PLAY;
          lives_n = 3'(LIVES);
        end
      end
      default: begin
        state_n = S_PLAY;
        arm_n   = '0;
        lives_n = 3'(LIVES);
      end
    endcase
  end

`ifdef DEAD_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_CYCLES);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Blink phase counter: runs only while staying in Dead, starts at 0 on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
    end else if (state == S_DEAD && state_n == S_DEAD) begin
      if (blink_cnt == BW'(2 * BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
    end
  end

  assign blink_on = (blink_cnt < BW'(BLINK_CYCLES));
`endif

  // Word code decode from the state register.
  always_comb begin
    wordSelect = 2'd0;
    case (state)
      S_PLAY:  wordSelect = 2'd0;
      S_ARM:   wordSelect = 2'd3;
      S_LIVE:  wordSelect = 2'd1;
`ifdef DEAD_BLINK_EN
      S_DEAD:  wordSelect = blink_on ? 2'd2 : 2'd3;
`else
      S_DEAD:  wordSelect = 2'd2;
`endif
      default: wordSelect = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_life_word_fsm.sv
// tb_life_word_fsm: directed table plus randomized run against a behavioural model of life_word_fsm.
// Latency: outputs are sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_life_word_fsm;

  localparam int DEB   = 4;
  localparam int BLANK = 8;
  localparam int NLIV  = 3;
  localparam int BLINK = 5;

  logic       clk;
  logic       reset;
  logic       btn;
  logic       hit;
  logic [1:0] wordSelect;
  logic [2:0] lives;
  logic       press;

  int checks   = 0;
  int failures = 0;

  life_word_fsm #(
    .DEBOUNCE_CYCLES(DEB),
    .BLANK_CYCLES(BLANK),
    .LIVES(NLIV),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .hit(hit),
    .wordSelect(wordSelect),
    .lives(lives),
    .press(press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0=Play 1=Arm 2=Live 3=Dead.
  int m_s1, m_s2, m_db, m_run, m_due, m_press;
  int m_phase, m_arm_left, m_lives, m_age;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_due = 0; m_press = 0;
    m_phase = 0; m_arm_left = 0; m_lives = NLIV; m_age = 0;
  endtask

  task automatic model_update(input logic r, input logic b, input logic h);
    int old_press;
    if (r) begin
      model_reset();
    end else begin
      old_press = m_press;
      m_press = m_due;
      m_due = 0;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db = m_s2;
          m_run = 0;
          if (m_db == 1) m_due = 1;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(b);
      case (m_phase)
        0: if (old_press == 1) begin m_phase = 1; m_arm_left = BLANK; m_lives = NLIV; end
        1: begin m_arm_left--; if (m_arm_left == 0) m_phase = 2; end
        2: begin
          if (old_press == 1) begin
            m_phase = 0; m_lives = NLIV;
          end else if (h) begin
            m_lives--;
            if (m_lives == 0) begin m_phase = 3; m_age = 0; end
          end
        end
        default: begin
          m_age++;
          if (old_press == 1) begin m_phase = 0; m_lives = NLIV; end
        end
      endcase
    end
  endtask

  function automatic int dead_word(input int age);
`ifdef DEAD_BLINK_EN
    return (((age / BLINK) % 2) == 0) ? 2 : 3;
`else
    return 2;
`endif
  endfunction

  function automatic int model_word();
    case (m_phase)
      0: return 0;
      1: return 3;
      2: return 1;
      default: return dead_word(m_age);
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic h);
    reset = r; btn = b; hit = h;
    @(posedge clk);
    model_update(r, b, h);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       b;
    logic       h;
    int         n;
    logic       ws_any;
    logic [1:0] ws;
    logic [2:0] lv;
    logic       pr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cur_btn;
    int run_left;
    logic rr, hh;

    reset = 1'b1; btn = 1'b0; hit = 1'b0;
    model_reset();

    // rst btn hit n ws_any ws lives press
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  1'b0, 2'd0, 3'd3, 1'b0}); // reset held
    tbl.push_back('{1'b0, 1'b0, 1'b0, 20, 1'b0, 2'd0, 3'd3, 1'b0}); // idle static
    tbl.push_back('{1'b0, 1'b1, 1'b0, 2,  1'b0, 2'd0, 3'd3, 1'b0}); // bounce
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 2'd0, 3'd3, 1'b0}); // held press
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd0, 3'd3, 1'b1}); // press on 7th
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8,  1'b0, 2'd3, 3'd3, 1'b0}); // arm blank
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd1, 3'd3, 1'b0}); // live
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd1, 3'd3, 1'b0}); // release no pulse
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd1, 3'd2, 1'b0}); // hit 1
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2,  1'b0, 2'd1, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd1, 3'd1, 1'b0}); // hit 2
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2,  1'b0, 2'd1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd2, 3'd0, 1'b0}); // hit 3 -> dead
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2,  1'b0, 2'd2, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd2, 3'd0, 1'b0}); // hit 4 ignored
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b1, 2'd0, 3'd0, 1'b0}); // press from dead
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b1, 2'd0, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd0, 3'd3, 1'b0}); // back to play
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 2'd0, 3'd3, 1'b0}); // start again
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd0, 3'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8,  1'b0, 2'd3, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd1, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd1, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd1, 3'd2, 1'b0}); // lives=2
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2,  1'b0, 2'd1, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 2'd1, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd1, 3'd2, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1,  1'b0, 2'd0, 3'd3, 1'b0}); // press beats hit
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3,  1'b0, 2'd0, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 2'd0, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd0, 3'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5,  1'b0, 2'd3, 3'd3, 1'b0}); // arm timer reaches 4
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b0, 2'd0, 3'd3, 1'b0}); // reset mid-arm
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 2'd0, 3'd3, 1'b0}); // held through reset
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd0, 3'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8,  1'b0, 2'd3, 3'd3, 1'b0}); // full arm again
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'd1, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd1, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd1, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1,  1'b0, 2'd1, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1,  1'b0, 2'd1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'd2, 3'd0, 1'b0}); // dead entry

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].rst, tbl[i].b, tbl[i].h);
        if (!tbl[i].ws_any) chk($sformatf("vec%0d.%0d wordSelect", i, k), 8'(wordSelect), 8'(tbl[i].ws));
        chk($sformatf("vec%0d.%0d lives", i, k), 8'(lives), 8'(tbl[i].lv));
        chk($sformatf("vec%0d.%0d press", i, k), 8'(press), 8'(tbl[i].pr));
      end
    end

    // Dead display over 30 cycles from entry (blinks only with DEAD_BLINK_EN).
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("dead%0d wordSelect", i), 8'(wordSelect), 8'(dead_word(i)));
      chk($sformatf("dead%0d lives", i), 8'(lives), 8'd0);
    end

    // Randomized run against the model.
    step(1'b1, 1'b0, 1'b0);
    cur_btn = 0;
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        cur_btn = int'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      hh = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 499) == 0);
      step(rr, (cur_btn != 0), hh);
      chk("rand wordSelect", 8'(wordSelect), 8'(model_word()));
      chk("rand lives", 8'(lives), 8'(m_lives));
      chk("rand press", 8'(press), 8'(m_press));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
